rx_sync_fsm: RTL

// - Receive-side link control for one lane of the JESD204B receiver, on the 1.25GHz character clock.
// - Input: 10b/8b-decoded octets. It drives SYNC~ and runs code group synchronisation (CGS).
// - Checks the initial lane alignment sequence (ILAS), then delivers frame-aligned user octets.
// - Undoes /F/ and /A/ character replacement in the data phase.
// - Counts link errors and drops back to CGS on excess errors or on request.

---
 rtl/rx_sync_fsm.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/rx_sync_fsm.sv
// Receive-side JESD204B lane link controller.
// Runs code group synchronisation and drives SYNC~, then checks the initial lane alignment
// sequence. After that it delivers frame-aligned user octets with /F/ and /A/ replacement
// undone, and counts data-phase link errors.
module rx_sync_fsm #(
    parameter int F          = 8,
    parameter int K          = 4,
    parameter int ILAS_MF    = 4,
    parameter int CGS_K_CNT  = 4,
    parameter int ERR_THRESH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] i_data,
    input  logic       i_k,
    input  logic       i_vld,
    input  logic       i_code_err,
    input  logic       i_lmfc_edge,
    input  logic       i_resync_req,
    output logic       o_sync_n,
    output logic [2:0] o_state,
    output logic [7:0] o_data,
    output logic       o_data_vld,
    output logic       o_sof,
    output logic       o_somf,
    output logic       o_k_replaced,
    output logic       o_ilas_done,
    output logic [7:0] o_err_cnt
);

    localparam int POS_W = (F > 1) ? $clog2(F) : 1;
    localparam int FRM_W = (K > 1) ? $clog2(K) : 1;
    localparam int MF_W  = (ILAS_MF > 1) ? $clog2(ILAS_MF) : 1;
    localparam int KC_W  = $clog2(CGS_K_CNT + 1);

    localparam logic [POS_W-1:0] POS_LAST = POS_W'(F - 1);
    localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(K - 1);
    localparam logic [MF_W-1:0]  MF_LAST  = MF_W'(ILAS_MF - 1);
    localparam logic [MF_W-1:0]  MF_ONE   = MF_W'(1);
    localparam logic [KC_W-1:0]  KC_LAST  = KC_W'(CGS_K_CNT - 1);
    localparam logic [KC_W-1:0]  KC_ONE   = KC_W'(1);
    localparam logic [7:0]       ERR_TH   = 8'(ERR_THRESH);

    localparam logic [7:0] CH_K = 8'hBC;
    localparam logic [7:0] CH_R = 8'h1C;
    localparam logic [7:0] CH_Q = 8'h9C;
    localparam logic [7:0] CH_A = 8'h7C;
    localparam logic [7:0] CH_F = 8'hFC;

    typedef enum logic [2:0] {
        CS_INIT      = 3'd0,
        CS_SYNCED    = 3'd1,
        CS_WAIT_ILAS = 3'd2,
        CS_ILAS      = 3'd3,
        CS_DATA      = 3'd4
    } state_t;

    state_t           state;
    logic [KC_W-1:0]  kcnt;
    // Position of the octet arriving this cycle (octet / frame / multiframe).
    logic [POS_W-1:0] pos;
    logic [FRM_W-1:0] frame;
    logic [MF_W-1:0]  mf;
    // Last delivered octet of the most recent frame, source for /F/ and /A/ restoration.
    logic [7:0]       last_octet;

    logic             err, is_kk, is_r, is_q, is_a, is_f;
    logic             pos_last, frame_last, mf_last;
    logic [POS_W-1:0] pos_nxt;
    logic [FRM_W-1:0] frame_nxt;
    logic [MF_W-1:0]  mf_nxt;
    logic             ilas_bad, repl, data_err, fail;
    logic [7:0]       ecnt_nxt;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign o_state = state;

    // Decode the incoming octet against the current position and decide whether the link drops to INIT.
    always_comb begin
        err        = i_vld & i_code_err;
        is_kk      = i_k & (i_data == CH_K);
        is_r       = i_k & (i_data == CH_R);
        is_q       = i_k & (i_data == CH_Q);
        is_a       = i_k & (i_data == CH_A);
        is_f       = i_k & (i_data == CH_F);
        pos_last   = (pos == POS_LAST);
        frame_last = (frame == FRM_LAST);
        mf_last    = (mf == MF_LAST);

        pos_nxt   = pos_last ? '0 : pos + 1'b1;
        frame_nxt = frame;
        mf_nxt    = mf;
        if (pos_last) begin
            frame_nxt = frame_last ? '0 : frame + 1'b1;
            if (frame_last)
                mf_nxt = mf + 1'b1;
        end

        ilas_bad = err
                 | ((pos == '0) & (frame == '0) & ~is_r)
                 | ((mf == MF_ONE) & (frame == '0) & (pos == POS_ONE) & ~is_q)
                 | (frame_last & pos_last & ~is_a);

        // Any frame-last position accepts /F/; /A/ is legal there too (it covers the multiframe end).
        repl     = ~err & pos_last & (is_f | is_a);
        data_err = err | (i_k & ~repl);
        ecnt_nxt = data_err ? sat_inc8(o_err_cnt) : o_err_cnt;

        case (state)
            CS_INIT:      fail = 1'b0;
            CS_SYNCED:    fail = i_vld & (err | ~is_kk);
            CS_WAIT_ILAS: fail = i_vld & (err | ~(is_kk | is_r));
            CS_ILAS:      fail = i_vld & ilas_bad;
            CS_DATA:      fail = i_vld & ((ecnt_nxt >= ERR_TH) | (is_kk & (kcnt == KC_ONE)));
            default:      fail = 1'b1;
        endcase
    end

    // Link state machine with all outputs registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= CS_INIT;
            o_sync_n     <= 1'b0;
            o_data       <= '0;
            o_data_vld   <= 1'b0;
            o_sof        <= 1'b0;
            o_somf       <= 1'b0;
            o_k_replaced <= 1'b0;
            o_ilas_done  <= 1'b0;
            o_err_cnt    <= '0;
            kcnt         <= '0;
            pos          <= '0;
            frame        <= '0;
            mf           <= '0;
            last_octet   <= '0;
        end else begin
            o_data_vld   <= 1'b0;
            o_sof        <= 1'b0;
            o_somf       <= 1'b0;
            o_k_replaced <= 1'b0;
            if (i_resync_req || fail) begin
                // The error that trips the threshold is still counted.
                if (!i_resync_req && state == CS_DATA)
                    o_err_cnt <= ecnt_nxt;
                state       <= CS_INIT;
                o_sync_n    <= 1'b0;
                o_ilas_done <= 1'b0;
                kcnt        <= '0;
                pos         <= '0;
                frame       <= '0;
                mf          <= '0;
            end else begin
                case (state)
                    CS_INIT: begin
                        if (i_vld) begin
                            if (is_kk && !err) begin
                                if (kcnt == KC_LAST) begin
                                    state     <= CS_SYNCED;
                                    kcnt      <= '0;
                                    o_err_cnt <= '0;
                                end else begin
                                    kcnt <= kcnt + 1'b1;
                                end
                            end else begin
                                kcnt <= '0;
                            end
                        end
                    end
                    CS_SYNCED: begin
                        if (i_lmfc_edge) begin
                            state    <= CS_WAIT_ILAS;
                            o_sync_n <= 1'b1;
                        end
                    end
                    CS_WAIT_ILAS: begin
                        // The first /R/ is ILAS octet 0; counters step past it.
                        if (i_vld && is_r) begin
                            state <= CS_ILAS;
                            pos   <= pos_nxt;
                            frame <= frame_nxt;
                            mf    <= mf_nxt;
                        end
                    end
                    CS_ILAS: begin
                        if (i_vld) begin
                            if (pos_last && frame_last && mf_last) begin
                                state       <= CS_DATA;
                                o_ilas_done <= 1'b1;
                                pos         <= '0;
                                frame       <= '0;
                                mf          <= '0;
                            end else begin
                                pos   <= pos_nxt;
                                frame <= frame_nxt;
                                mf    <= mf_nxt;
                            end
                        end
                    end
                    CS_DATA: begin
                        if (i_vld) begin
                            o_data       <= repl ? last_octet : i_data;
                            o_data_vld   <= 1'b1;
                            o_sof        <= (pos == '0);
                            o_somf       <= (pos == '0) && (frame == '0);
                            o_k_replaced <= repl;
                            o_err_cnt    <= ecnt_nxt;
                            kcnt         <= is_kk ? kcnt + 1'b1 : '0;
                            if (pos_last)
                                last_octet <= repl ? last_octet : i_data;
                            pos   <= pos_nxt;
                            frame <= frame_nxt;
                        end
                    end
                    default: state <= CS_INIT;
                endcase
            end
        end
    end

endmodule
